// File: rtl/simple_st0_out_buffer_pkg.sv
// rtl/simple_st0_out_buffer_pkg.sv - shared sample types for the stage 0 output buffer
package simple_st0_out_buffer_pkg;

    typedef logic [31:0] float_24_8;

    typedef struct packed {
        logic      lst;
        logic      fst;
        float_24_8 data;
    } out_buf_entry_t;

endpackage

// File: rtl/simple_st0_out_buffer_if.sv
// rtl/simple_st0_out_buffer_if.sv - stage 0 output / stage 1 input handshake bundle
interface simple_st0_out_buffer_if;
    import simple_st0_out_buffer_pkg::*;

    float_24_8 stage_0_data_out;
    logic      stage_0_data_out_vld;
    logic      stage_0_data_out_fst;
    logic      stage_0_data_out_rdy;
    float_24_8 stage_1_data_in;
    logic      stage_1_data_in_vld;
    logic      stage_1_data_in_fst;
    logic      stage_1_data_in_lst;
    logic      stage_1_data_in_rdy;

    // buffer side
    modport slave (
        input  stage_0_data_out, stage_0_data_out_vld, stage_0_data_out_fst, stage_1_data_in_rdy,
        output stage_0_data_out_rdy, stage_1_data_in, stage_1_data_in_vld,
        output stage_1_data_in_fst, stage_1_data_in_lst
    );

    // producer/consumer side
    modport master (
        output stage_0_data_out, stage_0_data_out_vld, stage_0_data_out_fst, stage_1_data_in_rdy,
        input  stage_0_data_out_rdy, stage_1_data_in, stage_1_data_in_vld,
        input  stage_1_data_in_fst, stage_1_data_in_lst
    );

endinterface

// File: rtl/simple_fifo_sync.sv
// rtl/simple_fifo_sync.sv - generic DEPTH x WIDTH register FIFO with occupancy output
module simple_fifo_sync #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 34
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LEVEL_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LEVEL_FULL);
    assign empty   = (level == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    // Stale RAM contents never leak out while empty.
    assign rdata   = empty ? '0 : mem[rptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            if (do_push && !do_pop)      level <= level + 1'b1;
            else if (do_pop && !do_push) level <= level - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/simple_st0_out_buffer.sv
// rtl/simple_st0_out_buffer.sv - frames stage 0 samples and buffers them for stage 1
module simple_st0_out_buffer
    import simple_st0_out_buffer_pkg::*;
#(
    parameter int FRAME_LEN = 6,
    parameter int DEPTH     = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    simple_st0_out_buffer_if.slave io,
    output logic                   frame_err,
    input  logic                   frame_err_clr,
    output logic [7:0]             frame_count,
    output logic [$clog2(DEPTH):0] level
);
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_FRAME = 1'b1;
    localparam logic [5:0] LAST_IDX = 6'(FRAME_LEN - 1);

    logic [0:0]     state;
    logic [5:0]     idx;
    logic           full;
    logic           empty;
    logic           push;
    logic           wr_en;
    logic           pop;
    logic           err_set;
    logic           in_fst;
    out_buf_entry_t wr_entry;
    out_buf_entry_t rd_entry;

    assign in_fst  = io.stage_0_data_out_fst;
    assign io.stage_0_data_out_rdy = ~full;
    assign push    = io.stage_0_data_out_vld & ~full;
    // Orphans in IDLE are swallowed; a fst inside a frame restarts it.
    assign wr_en   = push & ((state == ST_FRAME) | in_fst);
    assign err_set = push & (((state == ST_IDLE) & ~in_fst) | ((state == ST_FRAME) & in_fst));
    assign pop     = ~empty & io.stage_1_data_in_rdy;

    assign wr_entry.data = io.stage_0_data_out;
    assign wr_entry.fst  = in_fst;
    assign wr_entry.lst  = (state == ST_FRAME) & ~in_fst & (idx == LAST_IDX);

    assign io.stage_1_data_in_vld = ~empty;
    assign io.stage_1_data_in     = rd_entry.data;
    assign io.stage_1_data_in_fst = rd_entry.fst;
    assign io.stage_1_data_in_lst = rd_entry.lst;

    simple_fifo_sync #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(out_buf_entry_t))
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_en),
        .pop   (pop),
        .wdata (wr_entry),
        .rdata (rd_entry),
        .level (level),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            idx         <= '0;
            frame_count <= '0;
            frame_err   <= 1'b0;
        end else begin
            if (err_set)            frame_err <= 1'b1;
            else if (frame_err_clr) frame_err <= 1'b0;

            if (push) begin
                if (in_fst) begin
                    state <= ST_FRAME;
                    idx   <= 6'd1;
                end else if (state == ST_FRAME) begin
                    if (idx == LAST_IDX) begin
                        state       <= ST_IDLE;
                        idx         <= '0;
                        frame_count <= frame_count + 8'd1;
                    end else begin
                        idx <= idx + 6'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_simple_st0_out_buffer.sv
// tb/tb_simple_st0_out_buffer.sv - randomized self-checking bench against a queue reference model
module tb_simple_st0_out_buffer;
    localparam int FRAME_LEN = 6;
    localparam int DEPTH     = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       frame_err;
    logic       frame_err_clr = 1'b0;
    logic [7:0] frame_count;
    logic [$clog2(DEPTH):0] level;

    simple_st0_out_buffer_if bus ();

    simple_st0_out_buffer #(.FRAME_LEN(FRAME_LEN), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .io            (bus),
        .frame_err     (frame_err),
        .frame_err_clr (frame_err_clr),
        .frame_count   (frame_count),
        .level         (level)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // reference model: queue of {lst, fst, data}, frame position in samples
    logic [33:0] m_q [$];
    bit          m_in_frame;
    int          m_pos;
    bit          m_err;
    int          m_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_in_frame = 0;
        m_pos = 0;
        m_err = 0;
        m_cnt = 0;
    endtask

    task automatic check_outputs();
        logic [33:0] head;
        head = (m_q.size() != 0) ? m_q[0] : 34'd0;
        chk("rdy",   bus.stage_0_data_out_rdy, m_q.size() != DEPTH);
        chk("vld",   bus.stage_1_data_in_vld,  m_q.size() != 0);
        chk("level", level, m_q.size());
        chk("err",   frame_err, m_err);
        chk("count", frame_count, m_cnt % 256);
        chk("data",  bus.stage_1_data_in, head[31:0]);
        chk("fst",   bus.stage_1_data_in_fst, head[32]);
        chk("lst",   bus.stage_1_data_in_lst, head[33]);
    endtask

    // One clock: check state, drive inputs, then advance the model across the edge.
    task automatic cycle(input logic v, input logic f, input logic [31:0] d, input logic r, input logic c);
        bit push, pop, err_set;
        @(negedge clk);
        check_outputs();
        bus.stage_0_data_out     = d;
        bus.stage_0_data_out_vld = v;
        bus.stage_0_data_out_fst = f;
        bus.stage_1_data_in_rdy  = r;
        frame_err_clr            = c;
        @(posedge clk);
        push = v && (m_q.size() != DEPTH);
        pop  = (m_q.size() != 0) && r;
        err_set = 0;
        if (pop) void'(m_q.pop_front());
        if (push) begin
            if (f) begin
                if (m_in_frame) err_set = 1;
                m_q.push_back({1'b0, 1'b1, d});
                m_in_frame = 1;
                m_pos = 1;
            end else if (!m_in_frame) begin
                err_set = 1;
            end else if (m_pos == FRAME_LEN - 1) begin
                m_q.push_back({1'b1, 1'b0, d});
                m_in_frame = 0;
                m_pos = 0;
                m_cnt++;
            end else begin
                m_q.push_back({1'b0, 1'b0, d});
                m_pos++;
            end
        end
        if (err_set) m_err = 1;
        else if (c)  m_err = 0;
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, $urandom, r, 1'b0);
    endtask

    task automatic send_frame(input int n, input logic r);
        for (int k = 0; k < n; k++) cycle(1'b1, k == 0, $urandom, r, 1'b0);
    endtask

    initial begin
        bus.stage_0_data_out     = '0;
        bus.stage_0_data_out_vld = 1'b0;
        bus.stage_0_data_out_fst = 1'b0;
        bus.stage_1_data_in_rdy  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        idle(2, 1'b0);

        // single frame, consumer always ready
        for (int k = 0; k < FRAME_LEN; k++) cycle(1'b1, k == 0, 32'h3F800000 + k, 1'b1, 1'b0);
        idle(3, 1'b1);

        // back-pressure: 10 offered, 8 accepted, then drain
        for (int k = 0; k < 10; k++) cycle(1'b1, (k % FRAME_LEN) == 0, $urandom, 1'b0, 1'b0);
        idle(12, 1'b1);

        // short frame then error clear
        for (int k = 0; k < 4; k++) cycle(1'b1, (k == 0) || (k == 3), $urandom, 1'b1, 1'b0);
        for (int k = 1; k < FRAME_LEN; k++) cycle(1'b1, 1'b0, $urandom, 1'b1, 1'b0);
        idle(2, 1'b1);
        cycle(1'b0, 1'b0, 0, 1'b1, 1'b1);

        // orphan, clear, then clear racing a new orphan
        cycle(1'b1, 1'b0, 32'h12345678, 1'b1, 1'b0);
        idle(2, 1'b1);
        cycle(1'b0, 1'b0, 0, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 32'h0BAD0BAD, 1'b1, 1'b1);
        idle(2, 1'b1);
        cycle(1'b0, 1'b0, 0, 1'b1, 1'b1);

        // concurrent push/pop at level 4
        send_frame(4, 1'b0);
        for (int k = 0; k < 20; k++) cycle(1'b1, !m_in_frame, $urandom, 1'b1, 1'b0);
        idle(8, 1'b1);

        // long random run, enough frames to wrap frame_count
        for (int k = 0; k < 3000; k++) begin
            logic f;
            f = (!m_in_frame) ^ ($urandom_range(0, 59) == 0);
            cycle($urandom_range(0, 9) != 0, f, $urandom, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 29) == 0);
        end
        chk("wrapped", m_cnt >= 256, 1'b1);
        idle(10, 1'b1);

        // async reset mid-frame with level 5
        send_frame(5, 1'b0);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        model_reset();
        chk("rst_vld",   bus.stage_1_data_in_vld, 1'b0);
        chk("rst_rdy",   bus.stage_0_data_out_rdy, 1'b1);
        chk("rst_level", level, 0);
        bus.stage_0_data_out_vld = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        cycle(1'b1, 1'b0, 32'hDEADBEEF, 1'b1, 1'b0);
        send_frame(FRAME_LEN, 1'b1);
        idle(4, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
